// File: rtl/snitch_icache_perf_cnt.sv
// snitch_icache_perf_cnt
// Per-port, per-event performance counters for the L0 instruction cache.
// Counters are read through a single-outstanding request/response port.
// Optional macro SNITCH_ICACHE_PERF_SAT_EN: counters saturate at all-ones
// instead of wrapping (overflow flag is set in both modes).
module snitch_icache_perf_cnt #(
    parameter int NR_FETCH_PORTS = 2,
    parameter int CNT_WIDTH      = 32,
    parameter int ADDR_WIDTH     = $clog2(NR_FETCH_PORTS * 4)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NR_FETCH_PORTS*4-1:0] events_i,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic                        rd_req_i,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
    output logic                        rd_gnt_o,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [CNT_WIDTH-1:0]        rd_data_o,
    output logic                        rd_err_o,
    output logic [NR_FETCH_PORTS-1:0]   overflow_o
);

    localparam int NR_CNT = NR_FETCH_PORTS * 4;

    logic [CNT_WIDTH-1:0]      r_cnt [NR_CNT];
    logic [NR_FETCH_PORTS-1:0] r_overflow;
    logic                      r_valid;
    logic [CNT_WIDTH-1:0]      r_data;
    logic                      r_err;

    logic [NR_CNT-1:0]         w_inc;
    logic [NR_CNT-1:0]         w_wrap;
    logic [NR_CNT-1:0]         w_match;
    logic [CNT_WIDTH-1:0]      w_acc [NR_CNT+1];
    logic [NR_FETCH_PORTS-1:0] w_port_ovf;
    logic                      w_gnt;

    assign w_acc[0] = '0;

    // Counter index k = port*4 + evt, where evt 0 (miss) sits in the
    // port's top event bit and evt 3 (double hit) in its bottom bit.
    for (genvar k = 0; k < NR_CNT; k++) begin : g_cnt
        localparam int PORT = k / 4;
        localparam int EVT  = k % 4;

        assign w_inc[k]   = enable_i & events_i[PORT*4 + 3 - EVT];
        assign w_wrap[k]  = w_inc[k] & (&r_cnt[k]);
        assign w_match[k] = (rd_addr_i == ADDR_WIDTH'(k));
        // Read mux built as an OR chain of address-qualified counters.
        assign w_acc[k+1] = w_acc[k] | (r_cnt[k] & {CNT_WIDTH{w_match[k]}});

        // Counter update: reset and clear win over any increment.
        // NOTE: counters are discrete flops, not RAM, so they are reset
        // explicitly; the read path depends on them starting at zero.
        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                // NOTE: non-blocking assignment for every sequential state
                // update, so all counters sample pre-edge values together.
                r_cnt[k] <= '0;
`ifdef SNITCH_ICACHE_PERF_SAT_EN
            end else if (w_inc[k] && !(&r_cnt[k])) begin
`else
            end else if (w_inc[k]) begin
`endif
                r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
            end
        end
    end

    // A port overflows when any of its four counters hits all-ones on an increment.
    for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_port
        assign w_port_ovf[p] = |w_wrap[p*4 +: 4];
    end

    // Sticky per-port overflow flags, cleared only by reset or clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | w_port_ovf;
        end
    end

    // Accept a request when the response slot is empty or retiring now.
    assign w_gnt = !rst_i && rd_req_i && (!r_valid || rd_ready_i);

    // Response register: loads a pre-update snapshot on grant, holds while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_gnt) begin
            r_valid <= 1'b1;
            r_data  <= w_acc[NR_CNT];
            r_err   <= ~|w_match;
        end else if (rd_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign rd_gnt_o   = w_gnt;
    assign rd_valid_o = r_valid;
    assign rd_data_o  = r_data;
    assign rd_err_o   = r_err;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// tb_snitch_icache_perf_cnt
// Scoreboard bench: the driver issues stimulus and pushes expected read
// responses computed by an event-count model; a monitor pops and compares
// whenever the DUT presents a response. Honours SNITCH_ICACHE_PERF_SAT_EN.
module tb_snitch_icache_perf_cnt;

    localparam int NP   = 2;
    localparam int CW   = 4;
    localparam int AW   = 4;
    localparam int NC   = NP * 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [NC-1:0] events_i = '0;
    logic          enable_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          rd_req_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic          rd_gnt_o;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [CW-1:0] rd_data_o;
    logic          rd_err_o;
    logic [NP-1:0] overflow_o;

    snitch_icache_perf_cnt #(
        .NR_FETCH_PORTS(NP),
        .CNT_WIDTH     (CW),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .events_i  (events_i),
        .enable_i  (enable_i),
        .clear_i   (clear_i),
        .rd_req_i  (rd_req_i),
        .rd_addr_i (rd_addr_i),
        .rd_gnt_o  (rd_gnt_o),
        .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i),
        .rd_data_o (rd_data_o),
        .rd_err_o  (rd_err_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned data;
        bit          err;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model state.
    int unsigned m_cnt [NP][4];
    bit          m_ovf [NP];
    bit          m_valid = 1'b0;
    bit          m_after_rst = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock edge of the model, using the inputs currently applied.
    function automatic void model_edge();
        bit gnt;
        int unsigned a;
        if (rst_i) begin
            foreach (m_cnt[p, e]) m_cnt[p][e] = 0;
            foreach (m_ovf[p]) m_ovf[p] = 1'b0;
            m_valid = 1'b0;
            m_after_rst = 1'b1;
            exp_q.delete();
            return;
        end
        m_after_rst = 1'b0;
        gnt = rd_req_i && (!m_valid || rd_ready_i);
        a   = rd_addr_i;
        if (gnt) begin
            if (a < NC) exp_q.push_back('{data: m_cnt[a / 4][a % 4], err: 1'b0});
            else        exp_q.push_back('{data: 0, err: 1'b1});
            m_valid = 1'b1;
        end else if (rd_ready_i) begin
            m_valid = 1'b0;
        end
        if (clear_i) begin
            foreach (m_cnt[p, e]) m_cnt[p][e] = 0;
            foreach (m_ovf[p]) m_ovf[p] = 1'b0;
        end else if (enable_i) begin
            for (int p = 0; p < NP; p++) begin
                for (int e = 0; e < 4; e++) begin
                    // evt 0 = miss = port's bit 3 ... evt 3 = double hit = bit 0
                    if (events_i[p*4 + 3 - e]) begin
                        if (m_cnt[p][e] == MAXV) begin
                            m_ovf[p] = 1'b1;
`ifdef SNITCH_ICACHE_PERF_SAT_EN
                            m_cnt[p][e] = MAXV;
`else
                            m_cnt[p][e] = 0;
`endif
                        end else begin
                            m_cnt[p][e] = m_cnt[p][e] + 1;
                        end
                    end
                end
            end
        end
    endfunction

    // Apply one cycle of stimulus; called just after a rising edge.
    task automatic step(input logic [NC-1:0] ev, input logic en, input logic clr,
                        input logic req, input int addr, input logic rdy, input logic rst);
        logic [NP-1:0] ovf_exp;
        events_i   = ev;
        enable_i   = en;
        clear_i    = clr;
        rd_req_i   = req;
        rd_addr_i  = AW'(addr);
        rd_ready_i = rdy;
        rst_i      = rst;
        @(negedge clk_i);
        check("gnt", rd_gnt_o, !rst && req && (!m_valid || rdy));
        check("valid", rd_valid_o, m_valid);
        for (int p = 0; p < NP; p++) ovf_exp[p] = m_ovf[p];
        check("overflow", overflow_o, ovf_exp);
        if (m_after_rst) begin
            check("rst_data", rd_data_o, 0);
            check("rst_err", rd_err_o, 0);
        end
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic read(input int addr);
        step('0, 1'b1, 1'b0, 1'b1, addr, 1'b1, 1'b0);
        idle(1);
    endtask

    // Monitor: compare every presented response against the queue head,
    // and retire it when the consumer is ready.
    always @(negedge clk_i) begin
        if (rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                check("rd_data", rd_data_o, exp_q[0].data);
                check("rd_err", rd_err_o, exp_q[0].err);
                if (rd_ready_i === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset.
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(1);

        // Port 0 l0_hit for 5 cycles, read counter 1 (expects 5).
        for (int i = 0; i < 5; i++) step(8'b0000_0100, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        read(1);

        // Port 1 all events for 3 cycles, then back-to-back reads 4..7.
        for (int i = 0; i < 3; i++) step(8'b1111_0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        for (int a = 4; a < 8; a++) step('0, 1'b1, 1'b0, 1'b1, a, 1'b1, 1'b0);
        idle(1);

        // Seven misses on port 0, then clear together with a miss.
        for (int i = 0; i < 7; i++) step(8'b0000_1000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        read(0);
        step(8'b0000_1000, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        read(0);

        // Sixteen misses on a 4-bit counter: wrap (or saturate) and overflow.
        for (int i = 0; i < 16; i++) step(8'b0000_1000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        read(0);
        idle(1);

        // Stalled response while hits keep arriving; second request waits.
        step(8'b0000_0100, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'b0000_0100, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        step(8'b0000_0100, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        idle(2);

        // Enable low: counters hold.
        for (int i = 0; i < 3; i++) step(8'b1111_1111, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        read(5);

        // Out-of-range read, then reset while the response is pending.
        step('0, 1'b1, 1'b0, 1'b1, NC, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(NC'($urandom),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, NC + 3),
                 $urandom_range(0, 4) < 3,
                 $urandom_range(0, 149) == 0);
        end

        // Drain outstanding responses, then confirm none were lost.
        idle(4);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snitch_icache_perf_cnt.md
Name: snitch_icache_perf_cnt

Overview:
- Consumes the per-fetch-port `icache_events_t` strobes produced by the L0 instruction cache: l0_miss, l0_hit, l0_prefetch, l0_double_hit.
- Accumulates them in one counter per port per event.
- Exposes the counters through a single-outstanding request/response read port for the cluster peripheral block.
- Provides global enable and clear.

Parameters:
- NR_FETCH_PORTS, 2, number of fetch ports whose events are counted.
- CNT_WIDTH, 32, width of each counter; legal range 2..64.
- ADDR_WIDTH, $clog2(NR_FETCH_PORTS*4), derived; read address width, must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- events_i  in  NR_FETCH_PORTS*4  packed array of `icache_events_t`, one per port. Within port p: bit 4p+3 = l0_miss, 4p+2 = l0_hit, 4p+1 = l0_prefetch, 4p+0 = l0_double_hit.
- enable_i  in  1  counting enabled when high.
- clear_i  in  1  synchronous clear of all counters and overflow flags.
- rd_req_i  in  1  read request valid.
- rd_addr_i  in  ADDR_WIDTH  counter index = port*4 + evt. evt encoding: 0 miss, 1 hit, 2 prefetch, 3 double_hit.
- rd_gnt_o  out  1  request accepted this cycle.
- rd_valid_o  out  1  response valid.
- rd_ready_i  in  1  response consumed.
- rd_data_o  out  CNT_WIDTH  counter value.
- rd_err_o  out  1  address out of range; qualified by rd_valid_o.
- overflow_o  out  NR_FETCH_PORTS  sticky per-port flag: some counter of that port wrapped or saturated.

Behaviour:
- Reset (rst_i high at a clock edge): all counters 0; overflow_o 0; rd_valid_o 0; rd_data_o 0; rd_err_o 0. rd_gnt_o is combinational and 0 while rst_i is high.
- Increment: at each edge, counter[p][e] increments by 1 when enable_i && event bit set && !clear_i. Multiple bits of one port may be set in the same cycle; each counter increments independently.
- Clear: when clear_i is high, every counter becomes 0 and overflow_o becomes 0 at that edge. Clear wins over a simultaneous increment.
- Overflow: an increment from all-ones wraps to 0 and sets overflow_o[p] (without SNITCH_ICACHE_PERF_SAT_EN).
- Read handshake:
  - rd_gnt_o = rd_req_i && (!rd_valid_o || rd_ready_i). A new request is accepted in the same cycle the previous response retires.
  - On grant, the response register loads at the edge and rd_valid_o=1 on the next cycle. Latency is 1 cycle.
  - rd_data_o returns the counter value before that edge's increment or clear (pre-update snapshot).
  - rd_data_o and rd_err_o hold stable while rd_valid_o && !rd_ready_i.
  - rd_valid_o falls on the edge where rd_ready_i is high and no new grant occurs.
- Out of range: an address >= NR_FETCH_PORTS*4 returns rd_data_o=0 and rd_err_o=1, and is still granted.
- Reading does not modify counters.
- Reset mid-transaction: a pending response is dropped; rd_valid_o is 0 on the next cycle.
- enable_i low: counters hold. Reads and clear still operate.

Optional Feature:
- Macro: SNITCH_ICACHE_PERF_SAT_EN.
- Defined: counters saturate at 2^CNT_WIDTH-1 instead of wrapping. An increment attempted at saturation sets overflow_o[p]; the counter stays all-ones until clear_i or reset.
- Undefined: counters wrap modulo 2^CNT_WIDTH; overflow_o[p] is set on the wrap.

Test Plan:
- Reset, then port 0 l0_hit high for 5 cycles with enable_i=1, then read addr 1 -> rd_valid_o one cycle after grant, rd_data_o=5, rd_err_o=0.
- Port 1 events_i=4'b1111 for 3 cycles, then read addrs 4,5,6,7 back to back with rd_ready_i=1 -> rd_gnt_o high every cycle, data 3,3,3,3 on consecutive cycles.
- clear_i and l0_miss port 0 asserted in the same cycle after count 7 -> subsequent read of addr 0 returns 0.
- CNT_WIDTH=4, 16 misses on port 0:
  - Without macro: count 0 and overflow_o[0]=1.
  - With SNITCH_ICACHE_PERF_SAT_EN: count 15 and overflow_o[0]=1.
- Read granted with rd_ready_i=0 for 4 cycles while hits keep arriving -> rd_data_o stable at the grant-time value, rd_gnt_o=0 for a second pending request until ready.
- Read addr NR_FETCH_PORTS*4 (8 at default) -> rd_data_o=0, rd_err_o=1. Then rst_i asserted while rd_valid_o=1 -> rd_valid_o=0 next cycle.
